// File: rtl/fetch_sequencer_pkg.sv
// Shared types and widths for the fetch sequencer and its redirect latch.
package fetch_sequencer_pkg;

    localparam int XLEN   = 32;
    localparam int OFF_W  = 22;
    localparam int RS_W   = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HOLD  = 3'd2,
        S_STEP  = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PC_SEQ   = 2'b00,
        PC_REL   = 2'b01,
        PC_REG   = 2'b10,
        PC_UPPER = 2'b11
    } pc_func_e;

    typedef struct packed {
        logic [1:0]       func;
        logic [OFF_W-1:0] offset;
        logic [RS_W-1:0]  rs1;
    } pc_cmd_t;

endpackage

// File: rtl/fetch_sequencer_redirect_latch.sv
// Pending redirect register: a new capture always overwrites, a step clears.
module redirect_latch
    import fetch_sequencer_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    capture,
    input  logic    clear,
    input  pc_cmd_t cmd_in,
    output logic    pend_valid,
    output pc_cmd_t pend_cmd
);

    logic    pend_valid_q, pend_valid_d;
    pc_cmd_t pend_cmd_q, pend_cmd_d;

    // Capture wins over clear so a redirect arriving during the step survives it.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_cmd_d   = pend_cmd_q;
        if (capture) begin
            pend_valid_d = 1'b1;
            pend_cmd_d   = cmd_in;
        end else if (clear) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_cmd_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_cmd_q   <= pend_cmd_d;
        end
    end

    assign pend_valid = pend_valid_q;
    assign pend_cmd   = pend_cmd_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: IDLE -> FETCH -> HOLD -> STEP, redirects folded into STEP.
// Optional fetch-ack timeout with sticky fault enabled by FETCH_TIMEOUT_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [XLEN-1:0]   pc,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic              instr_valid,
    output logic [XLEN-1:0]   instr,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_func,
    input  logic [OFF_W-1:0]  redirect_offset,
    input  logic [RS_W-1:0]   redirect_rs1,
    output logic [1:0]        pc_func,
    output logic [OFF_W-1:0]  pc_offset,
    output logic [RS_W-1:0]   pc_rs1,
    output logic              pc_step,
    output logic              fault
);

    if (64'(TIMEOUT_CYCLES) >= (64'd1 << TO_W)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES does not fit in TO_W bits");
    end

    state_e          state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    pc_cmd_t         pc_cmd_q, pc_cmd_d;
    pc_cmd_t         redirect_in, redirect_cmd, pend_cmd;
    logic            pend_valid, redirect_now, timeout_hit;

    assign redirect_in  = '{func: redirect_func, offset: redirect_offset, rs1: redirect_rs1};
    assign redirect_now = redirect_valid | pend_valid;
    assign redirect_cmd = redirect_valid ? redirect_in : pend_cmd;

    redirect_latch u_redirect_latch (
        .clock      (clock),
        .reset      (reset),
        .capture    (redirect_valid),
        .clear      (state_q == S_STEP),
        .cmd_in     (redirect_in),
        .pend_valid (pend_valid),
        .pend_cmd   (pend_cmd)
    );

`ifdef FETCH_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = '0;
        if (state_q == S_FETCH && !imem_ack) to_cnt_d = to_cnt_q + TO_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end

    assign timeout_hit = (to_cnt_d == TO_W'(TIMEOUT_CYCLES));
    assign fault       = (state_q == S_FAULT);
`else
    assign timeout_hit = 1'b0;
    assign fault       = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_cmd_d = pc_cmd_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    if (redirect_now) begin
                        pc_cmd_d = redirect_cmd;
                        state_d  = S_STEP;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_HOLD: begin
                // A redirect takes the held word with it whether or not decode took it.
                if (redirect_now) begin
                    pc_cmd_d = redirect_cmd;
                    state_d  = S_STEP;
                end else if (instr_ready) begin
                    pc_cmd_d = '{func: PC_SEQ, offset: '0, rs1: '0};
                    state_d  = S_STEP;
                end
            end
            S_STEP:  state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            pc_cmd_q <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_cmd_q <= pc_cmd_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = imem_req ? pc : '0;
    assign instr_valid = (state_q == S_HOLD);
    assign instr       = instr_q;
    assign pc_step     = (state_q == S_STEP);
    assign pc_func     = pc_cmd_q.func;
    assign pc_offset   = pc_cmd_q.offset;
    assign pc_rs1      = pc_cmd_q.rs1;

endmodule
